// File: rtl/regfile_32x32.sv
// 32 x 32-bit register file: two combinational read ports with write-through
// bypass, one synchronous write port, register 0 hardwired to zero.
module regfile_32x32 #(
    parameter int DATAW = 32,
    parameter int ADDRW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADDRW-1:0] ard1,
    input  logic [ADDRW-1:0] ard2,
    input  logic [ADDRW-1:0] awr,
    input  logic [DATAW-1:0] dwr,
    input  logic             wen,
    output logic [DATAW-1:0] dout1,
    output logic [DATAW-1:0] dout2
);

    localparam int unsigned DEPTH = 2 ** ADDRW;

    logic [DATAW-1:0] regs_q [DEPTH];
    logic [DATAW-1:0] regs_d [DEPTH];
    logic             wr_active;

    assign wr_active = wen && (awr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_active) begin
            regs_d[awr] = dwr;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass is suppressed under reset so every address reads zero while rst=1.
    always_comb begin
        dout1 = regs_q[ard1];
        if (!rst && wr_active && (awr == ard1)) begin
            dout1 = dwr;
        end
        if (rst || (ard1 == '0)) begin
            dout1 = '0;
        end
    end

    always_comb begin
        dout2 = regs_q[ard2];
        if (!rst && wr_active && (awr == ard2)) begin
            dout2 = dwr;
        end
        if (rst || (ard2 == '0)) begin
            dout2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed self-checking bench for regfile_32x32: reset, write/read,
// register 0 protection, bypass, reset-vs-write and a full address sweep.
module tb_regfile_32x32;

    logic        clk;
    logic        rst;
    logic [4:0]  ard1;
    logic [4:0]  ard2;
    logic [4:0]  awr;
    logic [31:0] dwr;
    logic        wen;
    logic [31:0] dout1;
    logic [31:0] dout2;

    // Destination-register mux model feeding the write address.
    logic        sel;
    logic [4:0]  din1;
    logic [4:0]  din2;

    int total;
    int bad;

    regfile_32x32 #(.DATAW(32), .ADDRW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .ard1  (ard1),
        .ard2  (ard2),
        .awr   (awr),
        .dwr   (dwr),
        .wen   (wen),
        .dout1 (dout1),
        .dout2 (dout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wen = 1'b0; awr = '0; dwr = '0; ard1 = 5'd5; ard2 = 5'd31;
        step();
        total++;
        if (dout1 !== 32'h0 || dout2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_init dout1=%h dout2=%h expected 0/0", dout1, dout2);
        end
        rst = 1'b0;
        wen = 1'b1; awr = 5'd5; dwr = 32'hDEADBEEF;
        step();
        wen = 1'b0;
        #1;
        total++;
        if (dout1 !== 32'hDEADBEEF || dout2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_prewrite dout1=%h dout2=%h expected deadbeef/0", dout1, dout2);
        end
        // Assert reset mid-cycle, well away from any clock edge.
        #1 rst = 1'b1;
        #1;
        total++;
        if (dout1 !== 32'h0 || dout2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_async dout1=%h dout2=%h expected 0/0", dout1, dout2);
        end
        #18 rst = 1'b0;
        #1;
        total++;
        if (dout1 !== 32'h0) begin
            bad++;
            $display("FAIL reset_cleared dout1=%h expected 0", dout1);
        end
        step();
    endtask

    task automatic test_basic();
        wen = 1'b1; awr = 5'd10; dwr = 32'h0000_1234;
        step();
        wen = 1'b0; ard1 = 5'd10;
        #1;
        total++;
        if (dout1 !== 32'h0000_1234) begin
            bad++;
            $display("FAIL basic_r10 dout1=%h expected 00001234", dout1);
        end
        wen = 1'b1; awr = 5'd30; dwr = 32'hFFFF_FFFF;
        step();
        wen = 1'b0; ard2 = 5'd30;
        #1;
        total++;
        if (dout2 !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL basic_r30 dout2=%h expected ffffffff", dout2);
        end
    endtask

    task automatic test_reg0();
        wen = 1'b1; awr = 5'd0; dwr = 32'hA5A5A5A5; ard1 = 5'd0;
        #1;
        total++;
        if (dout1 !== 32'h0) begin
            bad++;
            $display("FAIL reg0_before dout1=%h expected 0", dout1);
        end
        step();
        wen = 1'b0;
        #1;
        total++;
        if (dout1 !== 32'h0) begin
            bad++;
            $display("FAIL reg0_after dout1=%h expected 0", dout1);
        end
    endtask

    task automatic test_bypass();
        wen = 1'b1; awr = 5'd7; dwr = 32'h11;
        step();
        wen = 1'b0; ard1 = 5'd7; ard2 = 5'd7;
        #1;
        total++;
        if (dout1 !== 32'h11 || dout2 !== 32'h11) begin
            bad++;
            $display("FAIL bypass_hold dout1=%h dout2=%h expected 11/11", dout1, dout2);
        end
        wen = 1'b1; awr = 5'd7; dwr = 32'h22;
        #1;
        total++;
        if (dout1 !== 32'h22 || dout2 !== 32'h22) begin
            bad++;
            $display("FAIL bypass_both dout1=%h dout2=%h expected 22/22", dout1, dout2);
        end
        ard2 = 5'd10;
        #1;
        total++;
        if (dout1 !== 32'h22 || dout2 !== 32'h0000_1234) begin
            bad++;
            $display("FAIL bypass_addr_match dout1=%h dout2=%h expected 22/00001234", dout1, dout2);
        end
        ard2 = 5'd7;
        step();
        wen = 1'b0;
        #1;
        total++;
        if (dout1 !== 32'h22 || dout2 !== 32'h22) begin
            bad++;
            $display("FAIL bypass_after dout1=%h dout2=%h expected 22/22", dout1, dout2);
        end
    endtask

    task automatic test_hold();
        wen = 1'b0; awr = 5'd7; dwr = 32'hBAD0BAD0;
        step();
        total++;
        if (dout1 !== 32'h22) begin
            bad++;
            $display("FAIL hold_wen0 dout1=%h expected 22", dout1);
        end
    endtask

    task automatic test_reset_vs_write();
        rst = 1'b1; wen = 1'b1; awr = 5'd3; dwr = 32'h55;
        step();
        #2 rst = 1'b0;
        wen = 1'b0; ard1 = 5'd3; ard2 = 5'd10;
        #1;
        total++;
        if (dout1 !== 32'h0 || dout2 !== 32'h0) begin
            bad++;
            $display("FAIL rst_vs_write dout1=%h dout2=%h expected 0/0", dout1, dout2);
        end
        wen = 1'b1; awr = 5'd3; dwr = 32'h77;
        step();
        wen = 1'b0;
        #1;
        total++;
        if (dout1 !== 32'h77) begin
            bad++;
            $display("FAIL first_write_after_rst dout1=%h expected 77", dout1);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp1;
        logic [31:0] exp2;
        for (int i = 1; i < 32; i++) begin
            sel = i[0];
            din1 = sel ? ~5'(i) : 5'(i);
            din2 = sel ? 5'(i) : ~5'(i);
            awr = sel ? din2 : din1;
            dwr = 32'(i * 3);
            wen = 1'b1;
            step();
        end
        wen = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ard1 = 5'(a);
            ard2 = 5'(31 - a);
            #1;
            exp1 = 32'(a * 3);
            exp2 = 32'((31 - a) * 3);
            total++;
            if (dout1 !== exp1 || dout2 !== exp2) begin
                bad++;
                $display("FAIL sweep a=%0d dout1=%h dout2=%h expected %h/%h", a, dout1, dout2, exp1, exp2);
            end
        end
    endtask

    task automatic test_back_to_back();
        wen = 1'b1; awr = 5'd12; dwr = 32'h0101_0101;
        step();
        dwr = 32'h0202_0202;
        step();
        wen = 1'b0; ard1 = 5'd12; ard2 = 5'd13;
        #1;
        total++;
        if (dout1 !== 32'h0202_0202 || dout2 !== 32'd39) begin
            bad++;
            $display("FAIL back_to_back dout1=%h dout2=%h expected 02020202/00000027", dout1, dout2);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        sel = 1'b0; din1 = '0; din2 = '0;
        test_reset();
        test_basic();
        test_reg0();
        test_bypass();
        test_hold();
        test_reset_vs_write();
        test_sweep();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
